// File: rtl/cache_pkg.sv
// Shared cache definitions: way geometry, sequencer state encoding and the
// per-set tree-PLRU storage type.
package cache_pkg;

  localparam int unsigned WAYS      = 8;
  localparam int unsigned WAY_BITS  = 3;
  localparam int unsigned PLRU_BITS = 7;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    REFILL,
    RESP
  } state_t;

  // Node n has children 2n+1 / 2n+2; node 3+k picks between ways 2k and 2k+1.
  typedef logic [PLRU_BITS-1:0] plru_t;

endpackage

// File: rtl/plru_tree.sv
// Combinational 8-way tree pseudo-LRU: victim selection and access update.
//   plru      : current tree bits for one set
//   acc_way   : way being accessed (hit way or refilled victim)
//   victim    : way reached by following the current bits (0 = left)
//   plru_next : tree bits after accessing acc_way (path points away from it)
module plru_tree
  import cache_pkg::*;
(
  input  plru_t                plru,
  input  logic [WAY_BITS-1:0]  acc_way,
  output logic [WAY_BITS-1:0]  victim,
  output plru_t                plru_next
);

  logic       lvl1_bit;
  logic       lvl2_bit;
  logic [2:0] leaf_node;
  logic [2:0] acc_mid_node;
  logic [2:0] acc_leaf_node;

  // Victim walk: root, then node 1/2, then leaf node 3..6.
  always_comb begin
    lvl1_bit  = plru[0] ? plru[2] : plru[1];
    leaf_node = 3'd3 + {1'b0, plru[0], lvl1_bit};
    lvl2_bit  = plru[leaf_node];
    victim    = {plru[0], lvl1_bit, lvl2_bit};
  end

  // Access update: each node on the path gets the inverse of the branch taken.
  always_comb begin
    acc_mid_node  = 3'd1 + {2'b00, acc_way[2]};
    acc_leaf_node = 3'd3 + {1'b0, acc_way[2:1]};
    plru_next                = plru;
    plru_next[0]             = ~acc_way[2];
    plru_next[acc_mid_node]  = ~acc_way[1];
    plru_next[acc_leaf_node] = ~acc_way[0];
  end

endmodule

// File: rtl/way_replace_ctrl.sv
// Lookup/replacement sequencer for an 8-way set-associative cache.
// Encodes the hit way, or on a miss picks a tree-PLRU victim and runs the
// refill handshake; updates the set's PLRU and returns the way number.
//   req_valid/req_ready/req_set/hit_vec : lookup request (accepted in IDLE)
//   resp_valid/resp_ready/resp_hit/resp_way : response to the datapath
//   refill_req/refill_way/refill_done   : handshake with the fill engine
//   err_multi_hit                       : pulse when more than one way hits
module way_replace_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned NUM_SETS = 16,
  parameter int unsigned SET_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [SET_BITS-1:0]  req_set,
  input  logic [WAYS-1:0]      hit_vec,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_hit,
  output logic [WAY_BITS-1:0]  resp_way,
  output logic                 refill_req,
  output logic [WAY_BITS-1:0]  refill_way,
  input  logic                 refill_done,
  output logic                 err_multi_hit
);

  state_t               state;
  logic [SET_BITS-1:0]  set_q;
  logic [WAYS-1:0]      hit_q;
  plru_t                plru_mem [NUM_SETS];

  logic [WAY_BITS-1:0]  hit_way;
  logic [WAY_BITS-1:0]  acc_way;
  logic [WAY_BITS-1:0]  victim;
  plru_t                plru_next;

  assign req_ready = (state == IDLE);

  // Lowest set bit wins; a multi-hit is serviced as a hit on that way.
  always_comb begin
    hit_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_q[i]) hit_way = WAY_BITS'(i);
    end
  end

  // In REFILL the victim is held in refill_way, so it doubles as the access way.
  assign acc_way = (state == LOOKUP) ? hit_way : refill_way;

  plru_tree u_plru_tree (
    .plru      (plru_mem[set_q]),
    .acc_way   (acc_way),
    .victim    (victim),
    .plru_next (plru_next)
  );

  // Sequencer with registered outputs and the PLRU flop array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      set_q         <= '0;
      hit_q         <= '0;
      resp_valid    <= 1'b0;
      resp_hit      <= 1'b0;
      resp_way      <= '0;
      refill_req    <= 1'b0;
      refill_way    <= '0;
      err_multi_hit <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) plru_mem[s] <= '0;
    end else begin
      err_multi_hit <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            set_q         <= req_set;
            hit_q         <= hit_vec;
            // x & (x-1) is nonzero exactly when two or more bits are set.
            err_multi_hit <= |(hit_vec & (hit_vec - WAYS'(1)));
            state         <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (|hit_q) begin
            plru_mem[set_q] <= plru_next;
            resp_hit        <= 1'b1;
            resp_way        <= hit_way;
            resp_valid      <= 1'b1;
            state           <= RESP;
          end else begin
            refill_req <= 1'b1;
            refill_way <= victim;
            state      <= REFILL;
          end
        end
        REFILL: begin
          if (refill_done) begin
            plru_mem[set_q] <= plru_next;
            resp_hit        <= 1'b0;
            resp_way        <= refill_way;
            resp_valid      <= 1'b1;
            refill_req      <= 1'b0;
            state           <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
